// File: rtl/vend_pkg.sv
// Shared encodings for the vending payment path: FSM states, coin values, price formula terms.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ERR    = 3'd1,
    ST_PAY    = 3'd2,
    ST_VEND   = 3'd3,
    ST_CHANGE = 3'd4,
    ST_REFUND = 3'd5
  } vend_state_e;

  localparam logic [9:0] COIN_NICKEL  = 10'd5;
  localparam logic [9:0] COIN_DIME    = 10'd10;
  localparam logic [9:0] COIN_QUARTER = 10'd25;
  localparam logic [9:0] COIN_DOLLAR  = 10'd100;

  localparam logic [9:0] PRICE_BASE       = 10'd50;
  localparam logic [9:0] PRICE_TENS_STEP  = 10'd25;
  localparam logic [9:0] PRICE_UNITS_STEP = 10'd5;

  localparam int CREDIT_MAX_DEFAULT = 995;

  function automatic logic [9:0] coin_value(input logic [1:0] coin_type);
    logic [9:0] value;
    case (coin_type)
      2'b00:   value = COIN_NICKEL;
      2'b01:   value = COIN_DIME;
      2'b10:   value = COIN_QUARTER;
      default: value = COIN_DOLLAR;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/vend_payment_fsm_if.sv
// Selection, coin, change handshake and status bundle between the code-entry stage and the payment FSM.
// master drives selections/coins/acks; slave is the payment FSM.
interface vend_payment_fsm_if;
  logic [15:0] code_in;
  logic        select;
  logic        cancel;
  logic        coin_valid;
  logic [1:0]  coin_type;
  logic        change_ack;
  logic [9:0]  price_out;
  logic [9:0]  credit_out;
  logic        vend;
  logic [7:0]  vend_code;
  logic        err;
  logic        coin_reject;
  logic        change_valid;
  logic [9:0]  change_out;
  logic [2:0]  state_out;

  modport master (
    output code_in, select, cancel, coin_valid, coin_type, change_ack,
    input  price_out, credit_out, vend, vend_code, err, coin_reject,
           change_valid, change_out, state_out
  );

  modport slave (
    input  code_in, select, cancel, coin_valid, coin_type, change_ack,
    output price_out, credit_out, vend, vend_code, err, coin_reject,
           change_valid, change_out, state_out
  );
endinterface

// File: rtl/vend_payment_fsm_price_rom.sv
// Combinational price table: two BCD digits -> {valid, price in cents}; zero latency, no backpressure.
module price_rom
  import vend_pkg::*;
(
  input  logic [7:0] code,
  output logic       valid,
  output logic [9:0] price
);
  logic [3:0] tens;
  logic [3:0] units;

  assign tens  = code[7:4];
  assign units = code[3:0];
  assign valid = (tens >= 4'd1) && (tens <= 4'd4) && (units <= 4'd7);
  assign price = PRICE_BASE + PRICE_TENS_STEP * {6'd0, tens} + PRICE_UNITS_STEP * {6'd0, units};
endmodule

// File: rtl/vend_payment_fsm.sv
// Payment FSM: latches selection, accumulates coins, pulses vend, returns change via valid/ack (held until ack).
// Coin at cycle N -> credit/state at N+1, change_valid at N+2. Optional idle auto-refund under VEND_TIMEOUT_EN.
module vend_payment_fsm
  import vend_pkg::*;
#(
  parameter int CREDIT_MAX = CREDIT_MAX_DEFAULT
`ifdef VEND_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input logic               clk,
  input logic               reset,
  vend_payment_fsm_if.slave bus
);
  vend_state_e state, state_nxt;
  logic [9:0]  price_q, price_nxt;
  logic [9:0]  credit_q, credit_nxt;
  logic [9:0]  change_q, change_nxt;
  logic [7:0]  code_q, code_nxt;
  logic        coin_reject_q, coin_reject_nxt;
  logic        rom_valid;
  logic [9:0]  rom_price;
  logic [10:0] credit_sum;
  logic        coin_ok;
  logic        abort;

  price_rom u_price_rom (
    .code  (bus.code_in[7:0]),
    .valid (rom_valid),
    .price (rom_price)
  );

  // One extra bit so an overflowing coin can be detected before it is added.
  assign credit_sum = {1'b0, credit_q} + {1'b0, coin_value(bus.coin_type)};
  assign coin_ok    = bus.coin_valid && (state == ST_PAY) && (credit_sum <= 11'(CREDIT_MAX));

`ifdef VEND_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        timeout;

  assign timeout = (state == ST_PAY) && !bus.coin_valid && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign abort   = bus.cancel | timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if ((state != ST_PAY) || bus.coin_valid || (state_nxt != ST_PAY)) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  assign abort = bus.cancel;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      price_q       <= '0;
      credit_q      <= '0;
      change_q      <= '0;
      code_q        <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      price_q       <= price_nxt;
      credit_q      <= credit_nxt;
      change_q      <= change_nxt;
      code_q        <= code_nxt;
      coin_reject_q <= coin_reject_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    price_nxt       = price_q;
    code_nxt        = code_q;
    credit_nxt      = credit_q;
    change_nxt      = change_q;
    coin_reject_nxt = bus.coin_valid && !coin_ok;
    case (state)
      ST_IDLE: begin
        if (bus.select) begin
          if (rom_valid && (bus.code_in[15:8] == 8'd0)) begin
            state_nxt  = ST_PAY;
            price_nxt  = rom_price;
            code_nxt   = bus.code_in[7:0];
            credit_nxt = '0;
          end else begin
            state_nxt = ST_ERR;
          end
        end
      end
      ST_ERR: state_nxt = ST_IDLE;
      ST_PAY: begin
        if (coin_ok) begin
          credit_nxt = credit_sum[9:0];
        end
        // A coin arriving with cancel is still credited, and the refund includes it.
        if (abort) begin
          state_nxt  = ST_REFUND;
          change_nxt = credit_nxt;
        end else if (coin_ok && (credit_sum >= {1'b0, price_q})) begin
          state_nxt = ST_VEND;
        end
      end
      ST_VEND: begin
        change_nxt = credit_q - price_q;
        state_nxt  = ST_CHANGE;
      end
      ST_CHANGE, ST_REFUND: begin
        if ((change_q == 10'd0) || bus.change_ack) begin
          state_nxt  = ST_IDLE;
          credit_nxt = '0;
          change_nxt = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.price_out    = price_q;
  assign bus.credit_out   = credit_q;
  assign bus.vend         = (state == ST_VEND);
  assign bus.vend_code    = code_q;
  assign bus.err          = (state == ST_ERR);
  assign bus.coin_reject  = coin_reject_q;
  assign bus.change_valid = ((state == ST_CHANGE) || (state == ST_REFUND)) && (change_q != 10'd0);
  assign bus.change_out   = change_q;
  assign bus.state_out    = state;
endmodule
